// File: rtl/call_return_stack.sv
//------------------------------------------------------------------------------
// Module      : call_return_stack
// Description : Hardware LIFO of return addresses / stack-transfer words for
//               the multicycle control unit. A push captures data_in (PC on
//               jal, register/ALU word on lstk); the top of stack feeds the PC
//               mux (jst) and the memory data mux (sstk).
//
// Parameters  : DATA_W  entry width
//               DEPTH   number of entries (power of two, >= 2)
//               PTR_W   derived stack pointer width, $clog2(DEPTH)
//
// Ports       : clk        rising-edge clock
//               reset      synchronous, active-high reset
//               push       push data_in this cycle (level-sampled)
//               pop        discard top entry this cycle (level-sampled)
//               data_in    word to push
//               clear_err  clears sticky overflow/underflow flags
//               data_out   top of stack, 0 when empty (combinational)
//               empty      count == 0
//               full       count == DEPTH
//               count      number of valid entries, 0..DEPTH
//               overflow   sticky: push attempted while full
//               underflow  sticky: pop attempted while empty
//
// Build option: CALL_STACK_WRAP_EN - when defined, a push while full overwrites
//               the oldest entry instead of being dropped.
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module call_return_stack #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear_err,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W-1:0] SP_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  // Registered state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  // Storage write port, decoded combinationally
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [PTR_W-1:0]  top_idx;
  logic              is_empty;
  logic              is_full;

  // sp points at the next free slot; wraps naturally because DEPTH is 2^PTR_W.
  assign top_idx  = sp_q - SP_ONE;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_MAX);

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    mem_we      = 1'b0;
    mem_waddr   = sp_q;
    // Clear first so a same-cycle error below re-sets the flag (set wins).
    overflow_d  = clear_err ? 1'b0 : overflow_q;
    underflow_d = clear_err ? 1'b0 : underflow_q;

    unique case ({push, pop})
      2'b10: begin
        if (!is_full) begin
          mem_we  = 1'b1;
          sp_d    = sp_q + SP_ONE;
          count_d = count_q + CNT_ONE;
        end else begin
          overflow_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
          // Overwrite the oldest entry: the slot at sp is the bottom when full.
          mem_we = 1'b1;
          sp_d   = sp_q + SP_ONE;
`endif
        end
      end
      2'b01: begin
        if (!is_empty) begin
          sp_d    = sp_q - SP_ONE;
          count_d = count_q - CNT_ONE;
        end else begin
          underflow_d = 1'b1;
        end
      end
      2'b11: begin
        if (!is_empty) begin
          // Replace top in place; never an error, even when full.
          mem_we    = 1'b1;
          mem_waddr = top_idx;
        end else begin
          // Empty stack cannot be full (DEPTH >= 2), so this is a plain push.
          mem_we  = 1'b1;
          sp_d    = sp_q + SP_ONE;
          count_d = count_q + CNT_ONE;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not cleared by reset, but a push during reset must not land.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= data_in;
    end
  end

  // Top is visible in the same cycle a pop is asserted (jst timing).
  assign data_out  = is_empty ? '0 : mem_q[top_idx];
  assign empty     = is_empty;
  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_call_return_stack.sv
//------------------------------------------------------------------------------
// Module      : tb_call_return_stack
// Description : Self-checking bench for call_return_stack (DEPTH=4). A driver
//               applies directed operations and queues the hand-computed
//               state expected after each edge; a monitor pops and compares
//               on the falling edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_call_return_stack;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic              clear_err;
  logic [DATA_W-1:0] data_out;
  logic              empty;
  logic              full;
  logic [PTR_W:0]    count;
  logic              overflow;
  logic              underflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    int          cnt;
    logic [31:0] data;
    logic        emp;
    logic        ful;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t exp_q[$];

  call_return_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
    .clear_err (clear_err),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input string n, input int c, input logic [31:0] d,
                              input logic o, input logic u);
    exp_t e;
    e.name = n;
    e.cnt  = c;
    e.data = d;
    e.emp  = (c == 0);
    e.ful  = (c == DEPTH);
    e.ovf  = o;
    e.udf  = u;
    return e;
  endfunction

  // Apply one cycle of stimulus; queue the state expected after the edge.
  task automatic step(input logic p, input logic po, input logic [31:0] d,
                      input logic c, input logic r, input exp_t e);
    @(negedge clk);
    push      = p;
    pop       = po;
    data_in   = d;
    clear_err = c;
    reset     = r;
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  // Monitor: state is registered, so the falling edge is a stable sample point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (int'(count) != e.cnt || data_out !== e.data || empty !== e.emp ||
            full !== e.ful || overflow !== e.ovf || underflow !== e.udf) begin
          bad++;
          $display("FAIL %s: got cnt=%0d data=%h emp=%b full=%b ovf=%b udf=%b, exp cnt=%0d data=%h emp=%b full=%b ovf=%b udf=%b",
                   e.name, count, data_out, empty, full, overflow, underflow,
                   e.cnt, e.data, e.emp, e.ful, e.ovf, e.udf);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0; clear_err = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    step(0, 0, 32'h0, 0, 1, mk("reset", 0, 32'h0, 0, 0));

    // Basic LIFO
    step(1, 0, 32'h10, 0, 0, mk("push10", 1, 32'h10, 0, 0));
    step(1, 0, 32'h20, 0, 0, mk("push20", 2, 32'h20, 0, 0));
    step(1, 0, 32'h30, 0, 0, mk("push30", 3, 32'h30, 0, 0));
    step(0, 1, 32'h0,  0, 0, mk("pop1",   2, 32'h20, 0, 0));
    step(0, 1, 32'h0,  0, 0, mk("pop2",   1, 32'h10, 0, 0));
    step(0, 1, 32'h0,  0, 0, mk("pop3",   0, 32'h0,  0, 0));

    // Underflow, sticky hold, clear, set-wins-over-clear
    step(0, 1, 32'h0, 0, 0, mk("udf_set",     0, 32'h0, 0, 1));
    step(0, 0, 32'h0, 0, 0, mk("udf_hold",    0, 32'h0, 0, 1));
    step(0, 0, 32'h0, 1, 0, mk("udf_clear",   0, 32'h0, 0, 0));
    step(0, 1, 32'h0, 1, 0, mk("udf_setwins", 0, 32'h0, 0, 1));
    step(0, 0, 32'h0, 1, 0, mk("udf_clear2",  0, 32'h0, 0, 0));

    // Fill, then overflow
    step(1, 0, 32'hA1, 0, 0, mk("pushA1", 1, 32'hA1, 0, 0));
    step(1, 0, 32'hA2, 0, 0, mk("pushA2", 2, 32'hA2, 0, 0));
    step(1, 0, 32'hA3, 0, 0, mk("pushA3", 3, 32'hA3, 0, 0));
    step(1, 0, 32'hA4, 0, 0, mk("pushA4_full", 4, 32'hA4, 0, 0));
`ifdef CALL_STACK_WRAP_EN
    step(1, 0, 32'hA5, 0, 0, mk("ovf_A5",       4, 32'hA5, 1, 0));
    step(0, 0, 32'h0,  1, 0, mk("ovf_clear",    4, 32'hA5, 0, 0));
    step(1, 0, 32'hA6, 1, 0, mk("ovf_setwins",  4, 32'hA6, 1, 0));
    step(0, 0, 32'h0,  1, 0, mk("ovf_clear2",   4, 32'hA6, 0, 0));
    step(1, 1, 32'hB0, 0, 0, mk("replace_full", 4, 32'hB0, 0, 0));
    step(0, 1, 32'h0,  0, 0, mk("popf1", 3, 32'hA5, 0, 0));
    step(0, 1, 32'h0,  0, 0, mk("popf2", 2, 32'hA4, 0, 0));
    step(0, 1, 32'h0,  0, 0, mk("popf3", 1, 32'hA3, 0, 0));
`else
    step(1, 0, 32'hA5, 0, 0, mk("ovf_A5",       4, 32'hA4, 1, 0));
    step(0, 0, 32'h0,  1, 0, mk("ovf_clear",    4, 32'hA4, 0, 0));
    step(1, 0, 32'hA6, 1, 0, mk("ovf_setwins",  4, 32'hA4, 1, 0));
    step(0, 0, 32'h0,  1, 0, mk("ovf_clear2",   4, 32'hA4, 0, 0));
    step(1, 1, 32'hB0, 0, 0, mk("replace_full", 4, 32'hB0, 0, 0));
    step(0, 1, 32'h0,  0, 0, mk("popf1", 3, 32'hA3, 0, 0));
    step(0, 1, 32'h0,  0, 0, mk("popf2", 2, 32'hA2, 0, 0));
    step(0, 1, 32'h0,  0, 0, mk("popf3", 1, 32'hA1, 0, 0));
`endif
    step(0, 1, 32'h0, 0, 0, mk("popf4", 0, 32'h0, 0, 0));

    // Replace top; push+pop on empty acts as push without underflow
    step(1, 0, 32'h100, 0, 0, mk("push100",     1, 32'h100, 0, 0));
    step(1, 1, 32'h200, 0, 0, mk("replace200",  1, 32'h200, 0, 0));
    step(0, 1, 32'h0,   0, 0, mk("pop200",      0, 32'h0,   0, 0));
    step(1, 1, 32'h300, 0, 0, mk("pp_empty300", 1, 32'h300, 0, 0));
    step(0, 1, 32'h0,   0, 0, mk("pop300",      0, 32'h0,   0, 0));

    // jst: top sampled in the cycle pop is high, empty after the edge
    step(1, 0, 32'h44, 0, 0, mk("jal44_popcycle", 1, 32'h44, 0, 0));
    step(0, 1, 32'h0,  0, 0, mk("jst_after",      0, 32'h0,  0, 0));

    // Reset mid-sequence beats push, with a flag pending
    step(0, 1, 32'h0,  0, 0, mk("udf_pre_reset", 0, 32'h0,  0, 1));
    step(1, 0, 32'h11, 0, 0, mk("push11",        1, 32'h11, 0, 1));
    step(1, 0, 32'h22, 0, 0, mk("push22",        2, 32'h22, 0, 1));
    step(1, 0, 32'h33, 0, 1, mk("reset_push",    0, 32'h0,  0, 0));
    step(1, 0, 32'h55, 0, 0, mk("push55_post",   1, 32'h55, 0, 0));

    @(negedge clk);
    push = 1'b0; pop = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
